// File: rtl/raw_read_sequencer.sv
// raw_read_sequencer: VGA-timed raw Bayer read sequencer with phase bits and frame/line markers.
// Optional FIFO underrun guard enabled by defining RAW_READ_UNDERRUN_EN.
module raw_read_sequencer #(
  parameter int H_START  = 144,
  parameter int H_ACTIVE = 640,
  parameter int V_START  = 35,
  parameter int V_ACTIVE = 480,
  parameter bit BAYER_X0 = 1'b0,
  parameter bit BAYER_Y0 = 1'b0
) (
  input  logic        VGA_CLK,
  input  logic        RST_N,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic        iENABLE,
  input  logic        iFIFO_EMPTY,
  output logic        READ_Request,
  output logic [12:0] READ_Cont,
  output logic [12:0] V_Cont,
  output logic        oX_PHASE,
  output logic        oY_PHASE,
  output logic        oFRAME_START,
  output logic        oLINE_END,
  output logic        oFRAME_DONE,
  output logic        oUNDERRUN
);
  typedef enum logic [2:0] {IDLE, VSKIP, HWAIT, ACTIVE, LEND} state_t;
  localparam logic [12:0] H_LAST  = 13'(H_START - 1);
  localparam logic [12:0] A_LAST  = 13'(H_ACTIVE - 1);
  localparam logic [12:0] VS_LAST = 13'(V_START - 1);
  localparam logic [12:0] V_LAST  = 13'(V_ACTIVE - 1);
  state_t      state_q, state_d;
  logic        hs_q, vs_q, seen_q, seen_d;
  logic [12:0] h_cnt_q, h_cnt_d, skip_q, skip_d;
  logic [12:0] cont_q, cont_d, vcont_q, vcont_d;
  logic        req_q, req_d, xph_q, yph_q;
  logic        fstart_q, fstart_d, lend_q, lend_d, fdone_q, fdone_d, under_q, under_d;
  logic        hs_rise, hs_fall, vs_rise, vs_fall, uflow;
  assign hs_rise = VGA_HS & ~hs_q;
  assign hs_fall = ~VGA_HS & hs_q;
  assign vs_rise = VGA_VS & ~vs_q;
  assign vs_fall = ~VGA_VS & vs_q;
`ifdef RAW_READ_UNDERRUN_EN
  assign uflow = iFIFO_EMPTY;
`else
  logic unused_empty;
  assign unused_empty = iFIFO_EMPTY;
  assign uflow = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    seen_d   = seen_q;
    h_cnt_d  = h_cnt_q;
    skip_d   = skip_q;
    req_d    = 1'b0;
    cont_d   = '0;
    vcont_d  = vcont_q;
    fstart_d = 1'b0;
    lend_d   = 1'b0;
    fdone_d  = 1'b0;
    under_d  = under_q;
    if (state_q != IDLE && vs_fall) begin
      state_d = IDLE;
      vcont_d = '0;
    end else begin
      case (state_q)
        IDLE: if (vs_rise && iENABLE) begin
          state_d = (V_START == 0) ? HWAIT : VSKIP;
          skip_d  = '0;
          seen_d  = 1'b0;
        end
        VSKIP: if (hs_fall) begin
          state_d = (skip_q == VS_LAST) ? HWAIT : VSKIP;
          skip_d  = skip_q + 13'd1;
        end
        HWAIT: if (hs_rise) begin
          seen_d  = 1'b1;
          h_cnt_d = '0;
        end else if (seen_q) begin
          state_d  = (h_cnt_q == H_LAST) ? ACTIVE : HWAIT;
          req_d    = (h_cnt_q == H_LAST);
          fstart_d = (h_cnt_q == H_LAST) && (vcont_q == '0);
          h_cnt_d  = h_cnt_q + 13'd1;
        end
        ACTIVE: if (uflow) begin
          under_d = 1'b1;
          state_d = IDLE;
          vcont_d = '0;
        end else if (hs_fall || cont_q == A_LAST) begin
          state_d = LEND;
          lend_d  = 1'b1;
          fdone_d = (vcont_q == V_LAST);
          vcont_d = (vcont_q == V_LAST) ? 13'd0 : vcont_q + 13'd1;
        end else begin
          req_d  = 1'b1;
          cont_d = cont_q + 13'd1;
        end
        LEND: begin
          state_d = fdone_q ? IDLE : HWAIT;
          seen_d  = hs_rise;
          h_cnt_d = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // Sync samples reset high so a full low->high transition is required after reset.
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      seen_q   <= 1'b0;
      h_cnt_q  <= '0;
      skip_q   <= '0;
      req_q    <= 1'b0;
      cont_q   <= '0;
      vcont_q  <= '0;
      xph_q    <= 1'b0;
      yph_q    <= 1'b0;
      fstart_q <= 1'b0;
      lend_q   <= 1'b0;
      fdone_q  <= 1'b0;
      under_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hs_q     <= VGA_HS;
      vs_q     <= VGA_VS;
      seen_q   <= seen_d;
      h_cnt_q  <= h_cnt_d;
      skip_q   <= skip_d;
      req_q    <= req_d;
      cont_q   <= cont_d;
      vcont_q  <= vcont_d;
      xph_q    <= cont_d[0] ^ BAYER_X0;
      yph_q    <= vcont_d[0] ^ BAYER_Y0;
      fstart_q <= fstart_d;
      lend_q   <= lend_d;
      fdone_q  <= fdone_d;
      under_q  <= under_d;
    end
  end
  assign READ_Request = req_q;
  assign READ_Cont    = cont_q;
  assign V_Cont       = vcont_q;
  assign oX_PHASE     = xph_q;
  assign oY_PHASE     = yph_q;
  assign oFRAME_START = fstart_q;
  assign oLINE_END    = lend_q;
  assign oFRAME_DONE  = fdone_q;
  assign oUNDERRUN    = under_q;
endmodule

// File: tb/tb_raw_read_sequencer.sv
// tb_raw_read_sequencer: directed-vector bench for raw_read_sequencer (H_START=4 H_ACTIVE=8 V_START=2 V_ACTIVE=3).
module tb_raw_read_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, hs = 1'b1, vs = 1'b1, en = 1'b1, empty = 1'b0;
  logic req, xp, yp, fs, le, fd, ur;
  logic [12:0] rc, vc;
  int vecs = 0, errs = 0;
  int nreq = 0, nfs = 0, nle = 0, nfd = 0, hs_age = 0, fd_at = -1;
  int b_req, b_fs, b_le, b_fd, b_lead;
  int rcq[$], vcq[$], ypq[$], xpq[$], leadq[$];
  logic req_prev = 1'b0;
  always #5 clk = ~clk;
  raw_read_sequencer #(.H_START(4), .H_ACTIVE(8), .V_START(2), .V_ACTIVE(3)) dut (
    .VGA_CLK(clk), .RST_N(rst_n), .VGA_HS(hs), .VGA_VS(vs), .iENABLE(en), .iFIFO_EMPTY(empty),
    .READ_Request(req), .READ_Cont(rc), .V_Cont(vc), .oX_PHASE(xp), .oY_PHASE(yp),
    .oFRAME_START(fs), .oLINE_END(le), .oFRAME_DONE(fd), .oUNDERRUN(ur)
  );
  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // hs_age counts edges with HS sampled high; a burst lead is edges between first-high and first request
  always @(posedge clk) begin
    #1;
    hs_age = hs ? hs_age + 1 : 0;
    if (req) begin
      nreq++;
      rcq.push_back(int'(rc));
      vcq.push_back(int'(vc));
      ypq.push_back(int'(yp));
      xpq.push_back(int'(xp));
      if (!req_prev) leadq.push_back(hs_age - 1);
    end
    req_prev = req;
    if (fs) nfs++;
    if (le) nle++;
    if (fd) begin nfd++; fd_at = nreq; end
  end
  task automatic tk(input int n); repeat (n) @(negedge clk); endtask
  task automatic mark();
    b_req = nreq; b_fs = nfs; b_le = nle; b_fd = nfd; b_lead = leadq.size();
  endtask
  task automatic vs_pulse(); vs = 1'b0; tk(3); vs = 1'b1; tk(2); endtask
  task automatic hs_line(input int hi); hs = 1'b0; tk(2); hs = 1'b1; tk(hi); endtask
  task automatic frame(input int n); vs_pulse(); repeat (n) hs_line(16); endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    tk(2);
    check("reset_outs", {req, rc, vc, xp, yp, fs, le, fd, ur}, 40'd0);
    rst_n = 1'b1;
    tk(2);
    mark();
    frame(6);
    check("t1_reqs", nreq - b_req, 24);
    check("t1_fstart", nfs - b_fs, 1);
    check("t1_fdone", nfd - b_fd, 1);
    check("t1_fdone_at", fd_at, b_req + 24);
    check("t1_lend", nle - b_le, 3);
    check("t1_rc0", rcq[b_req], 0);
    check("t1_rc7", rcq[b_req + 7], 7);
    check("t1_rc8", rcq[b_req + 8], 0);
    check("t1_rc23", rcq[b_req + 23], 7);
    check("t1_xp3", xpq[b_req + 3], 1);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("t1_vc_line%0d", k), vcq[b_req + 8 * k], k);
      check($sformatf("t1_yp_line%0d", k), ypq[b_req + 8 * k], k % 2);
      check($sformatf("t1_lead_line%0d", k), leadq[b_lead + k], 4);
    end
    check("t1_vc_end", vc, 0);
    en = 1'b0;
    mark();
    vs_pulse();
    hs_line(16);
    hs_line(16);
    en = 1'b1;
    repeat (4) hs_line(16);
    check("t2_skip_reqs", nreq - b_req, 0);
    check("t2_skip_fstart", nfs - b_fs, 0);
    mark();
    frame(6);
    check("t2_next_reqs", nreq - b_req, 24);
    check("t2_next_fdone", nfd - b_fd, 1);
    mark();
    vs_pulse();
    hs_line(16);
    hs = 1'b0; tk(2); hs = 1'b1; tk(9);
    hs = 1'b0; tk(1);
    check("t3_req_drop", req, 0);
    check("t3_lend", le, 1);
    check("t3_vc", vc, 1);
    tk(1); hs = 1'b1; tk(16);
    repeat (3) hs_line(16);
    check("t3_reqs", nreq - b_req, 21);
    check("t3_rc_last", rcq[b_req + 4], 4);
    check("t3_next_rc", rcq[b_req + 5], 0);
    check("t3_next_vc", vcq[b_req + 5], 1);
    check("t3_lend_cnt", nle - b_le, 3);
    check("t3_fdone", nfd - b_fd, 1);
    mark();
    vs_pulse();
    hs_line(16);
    hs_line(16);
    hs = 1'b0; tk(2); hs = 1'b1; tk(7);
    check("t4_pre_rc", rc, 2);
    check("t4_pre_vc", vc, 1);
    vs = 1'b0; tk(1);
    check("t4_req", req, 0);
    check("t4_vc", vc, 0);
    check("t4_rc", rc, 0);
    tk(5);
    check("t4_reqs", nreq - b_req, 11);
    check("t4_fdone", nfd - b_fd, 0);
    mark();
    frame(6);
    check("t4_next_reqs", nreq - b_req, 24);
    check("t4_next_vc0", vcq[b_req], 0);
    check("t4_next_fdone", nfd - b_fd, 1);
    vs_pulse();
    hs_line(16);
    hs = 1'b0; tk(2); hs = 1'b1; tk(7);
    check("t5_pre_req", req, 1);
    rst_n = 1'b0;
    #1;
    check("t5_async_outs", {req, rc, vc, xp, yp, fs, le, fd, ur}, 40'd0);
    tk(2);
    rst_n = 1'b1;
    tk(9);
    mark();
    repeat (3) hs_line(16);
    check("t5_no_req", nreq - b_req, 0);
    mark();
    frame(6);
    check("t5_next_reqs", nreq - b_req, 24);
    mark();
    vs_pulse();
    hs_line(16);
    hs = 1'b0; tk(2); hs = 1'b1; tk(8);
    check("t6_pre_rc", rc, 3);
    empty = 1'b1; tk(1); empty = 1'b0;
`ifdef RAW_READ_UNDERRUN_EN
    check("t6_req", req, 0);
    check("t6_under", ur, 1);
`else
    check("t6_req", req, 1);
    check("t6_rc", rc, 4);
    check("t6_under", ur, 0);
`endif
    tk(7);
    repeat (4) hs_line(16);
`ifdef RAW_READ_UNDERRUN_EN
    check("t6_reqs", nreq - b_req, 4);
    check("t6_fdone", nfd - b_fd, 0);
    check("t6_under_hold", ur, 1);
`else
    check("t6_reqs", nreq - b_req, 24);
    check("t6_fdone", nfd - b_fd, 1);
    check("t6_under_hold", ur, 0);
`endif
    mark();
    frame(6);
    check("t6_next_reqs", nreq - b_req, 24);
`ifdef RAW_READ_UNDERRUN_EN
    check("t6_sticky", ur, 1);
`else
    check("t6_sticky", ur, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
